bcd_rtc_param: RTL and testbench
================================

Name: bcd_rtc_param

Overview:
- Single-clock-domain, parametrised successor to the ripple-clocked 24 h timer.
- Derives a 1 Hz enable from the system clock with an internal prescaler and keeps HH:MM:SS as BCD in the existing 24-bit digit layout.
- Adds run/stop, validated time load, a 12/24 h display mode with PM flag, an HH:MM alarm, and one-cycle carry pulses.
- Sits between the system clock and the 7-segment scan driver.

Parameters:
- TICK_DIV, 50000000, system-clock cycles per second; must be >= 1.
- DIV_W, 26, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = prescaler and time advance, 0 = both hold.
- mode_12h  input  1  level; 0 = 24 h display, 1 = 12 h display.
- load  input  1  one-cycle pulse; load load_time.
- load_time  input  24  BCD HHMMSS, 24 h format, same nibble layout as digit.
- load_err  output  1  one-cycle pulse; load rejected.
- alarm_set  input  1  one-cycle pulse; capture alarm_time.
- alarm_time  input  16  BCD HHMM, 24 h format.
- alarm_en  input  1  level; alarm output enabled.
- alarm  output  1  one-cycle pulse on alarm match.
- digit  output  24  [23:20] hour tens, [19:16] hour units, [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- pm  output  1  12 h mode PM flag; always 0 in 24 h mode.
- sec_tick  output  1  one-cycle pulse per second advance.
- min_tick  output  1  one-cycle pulse on seconds wrap 59->00.
- hour_tick  output  1  one-cycle pulse on minutes wrap 59->00.
- day_tick  output  1  one-cycle pulse on 23:59:59->00:00:00.

Behaviour:
- Reset (clk edge with rst=1):
  - time 00:00:00; prescaler 0; stored alarm 00:00.
  - All pulse outputs 0; load_err 0.
  - rst has priority over every other input.
- Internal state:
  - Time held as 24 h BCD registers.
  - digit and pm are combinational from the time registers and mode_12h: no extra latency, and a mode change shows immediately.
- Prescaler:
  - With run=1, counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1 it returns to 0 and the time advances by one second.
  - With run=0 it holds its value.
  - TICK_DIV=1 advances on every run cycle.
- Advance and carries:
  - Each BCD digit wraps at its own limit: seconds 59->00, minutes 59->00, hours 23->00.
  - sec_tick is registered, high during the cycle after the advancing edge.
  - min_tick, hour_tick and day_tick are asserted in that same cycle, only when the corresponding wrap occurred; at day wrap all four are high together.
- Load:
  - Valid when every nibble <= 9, seconds <= 59, minutes <= 59 and hours <= 23.
  - Valid load: time takes load_time on that edge; prescaler clears to 0; no tick pulses are generated.
  - Invalid load: time and prescaler unchanged; load_err high for the next cycle.
  - Load coinciding with a prescaler terminal count: the load wins and no advance occurs.
  - Load is accepted whether run is 0 or 1.
- Alarm:
  - alarm_set captures alarm_time without a validity check; an invalid value simply never matches.
  - alarm pulses in the same cycle as sec_tick when the new time equals the stored HH:MM:00 and alarm_en=1.
  - A loaded time that equals the alarm does not fire the alarm.
  - alarm_set on the same edge as a matching advance compares against the old stored value.
- 12 h display mapping, hour h to displayed hour and pm:
  - h=0 -> 12, pm=0.
  - h=1..11 -> h, pm=0.
  - h=12 -> 12, pm=1.
  - h=13..23 -> h-12, pm=1.
  - Minutes and seconds are unchanged.
  - Display hour tens is 0 or 1; the leading zero is still driven, no blanking.
- Reset mid-count: the prescaler phase is lost; the first advance occurs TICK_DIV run cycles after reset release.

Test Plan:
- TICK_DIV=4, rst then run=1 -> digit 0x000000; sec_tick every 4th cycle; digit 0x000001 after the first tick; prescaler holds while run=0 mid-count.
- Load 0x235958, run -> after 2 ticks digit 0x000000; sec_tick, min_tick, hour_tick and day_tick all high in that single cycle.
- Load 0x236000 and load 0x0A0000 -> load_err pulses one cycle each; digit unchanged; load on a terminal-count edge -> loaded value shown and no sec_tick.
- mode_12h=1 at times 00:15:00, 11:59:59, 12:00:00 and 13:05:00 -> digit 0x121500 pm=0, 0x115959 pm=0, 0x120000 pm=1, 0x010500 pm=1; toggling mode changes the display the same cycle.
- alarm_set 0x0701, alarm_en=1, load 0x070058 -> alarm pulses only with the sec_tick that shows 0x070100; repeat with alarm_en=0 -> no pulse; load 0x070100 directly -> no pulse.
- Assert rst during run at 0x123456 -> next cycle digit 0x000000, all pulses 0, stored alarm cleared (an alarm at 00:00 fires at the next day wrap if enabled).

Source files
------------

// File: rtl/bcd_rtc_param.sv
`default_nettype none
// ============================================================================
// Module      : bcd_rtc_param
// Description : 24 h BCD real-time clock on a single clock domain. A prescaler
//               derives the one-second advance from the system clock. Adds
//               run/stop, validated time load, 12/24 h display with PM flag,
//               an HH:MM alarm and one-cycle carry pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_rtc_param #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] load_time,
    output logic        load_err,
    input  logic        alarm_set,
    input  logic [15:0] alarm_time,
    input  logic        alarm_en,
    output logic        alarm,
    output logic [23:0] digit,
    output logic        pm,
    output logic        sec_tick,
    output logic        min_tick,
    output logic        hour_tick,
    output logic        day_tick
);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Time registers are always held in 24 h BCD; the 12 h view is derived.
    logic [7:0]       hh_q, hh_d;
    logic [7:0]       mm_q, mm_d;
    logic [7:0]       ss_q, ss_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      alm_time_q, alm_time_d;
    logic             sec_tick_q, sec_tick_d;
    logic             min_tick_q, min_tick_d;
    logic             hour_tick_q, hour_tick_d;
    logic             day_tick_q, day_tick_d;
    logic             alarm_q, alarm_d;
    logic             load_err_q, load_err_d;

    logic             w_load_ok;
    logic             w_tc;
    logic [4:0]       w_hbin;
    logic [4:0]       w_h12;
    logic [7:0]       w_disp_hh;
    logic             w_pm;

    // Two-digit BCD increment without wrap; callers handle the digit limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Load is accepted only for a legal 24 h BCD time.
    always_comb begin
        w_load_ok = (load_time[3:0]   <= 4'd9) &&
                    (load_time[7:4]   <= 4'd5) &&
                    (load_time[11:8]  <= 4'd9) &&
                    (load_time[15:12] <= 4'd5) &&
                    (((load_time[23:20] <= 4'd1) && (load_time[19:16] <= 4'd9)) ||
                     ((load_time[23:20] == 4'd2) && (load_time[19:16] <= 4'd3)));
    end

    // Next-state: load beats advance; an advance ripples carries through the digits.
    always_comb begin
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        div_d       = div_q;
        alm_time_d  = alarm_set ? alarm_time : alm_time_q;
        sec_tick_d  = 1'b0;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        alarm_d     = 1'b0;
        load_err_d  = 1'b0;
        w_tc        = run && (div_q == C_DIV_LAST);

        if (load) begin
            if (w_load_ok) begin
                hh_d  = load_time[23:16];
                mm_d  = load_time[15:8];
                ss_d  = load_time[7:0];
                div_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run) begin
            if (w_tc) begin
                div_d      = '0;
                sec_tick_d = 1'b1;
                if (ss_q == 8'h59) begin
                    ss_d       = 8'h00;
                    min_tick_d = 1'b1;
                    if (mm_q == 8'h59) begin
                        mm_d        = 8'h00;
                        hour_tick_d = 1'b1;
                        if (hh_q == 8'h23) begin
                            hh_d       = 8'h00;
                            day_tick_d = 1'b1;
                        end else begin
                            hh_d = bcd_inc(hh_q);
                        end
                    end else begin
                        mm_d = bcd_inc(mm_q);
                    end
                end else begin
                    ss_d = bcd_inc(ss_q);
                end
                // Compared against the alarm held before any same-edge alarm_set.
                alarm_d = alarm_en && ({hh_d, mm_d} == alm_time_q) && (ss_d == 8'h00);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            div_q       <= '0;
            alm_time_q  <= 16'h0000;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            div_q       <= div_d;
            alm_time_q  <= alm_time_d;
            sec_tick_q  <= sec_tick_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
            alarm_q     <= alarm_d;
            load_err_q  <= load_err_d;
        end
    end

    // 12/24 h display hour; combinational so a mode change shows at once.
    always_comb begin
        w_hbin    = ({1'b0, hh_q[7:4]} * 5'd10) + {1'b0, hh_q[3:0]};
        w_h12     = w_hbin - 5'd12;
        w_disp_hh = hh_q;
        w_pm      = 1'b0;
        if (mode_12h) begin
            if (w_hbin == 5'd0) begin
                w_disp_hh = 8'h12;
            end else if (w_hbin < 5'd12) begin
                w_disp_hh = hh_q;
            end else if (w_hbin == 5'd12) begin
                w_disp_hh = 8'h12;
                w_pm      = 1'b1;
            end else begin
                w_pm = 1'b1;
                if (w_h12 >= 5'd10) begin
                    w_disp_hh = {4'd1, 4'(w_h12 - 5'd10)};
                end else begin
                    w_disp_hh = {4'd0, w_h12[3:0]};
                end
            end
        end
    end

    assign digit     = {w_disp_hh, mm_q, ss_q};
    assign pm        = w_pm;
    assign sec_tick  = sec_tick_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;
    assign alarm     = alarm_q;
    assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_rtc_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_rtc_param
// Description : Self-checking bench for bcd_rtc_param (TICK_DIV=4). A
//               seconds-of-day reference model is compared against the DUT on
//               every falling edge; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_rtc_param;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst, run, mode_12h, load, alarm_set, alarm_en;
    logic [23:0] load_time;
    logic [15:0] alarm_time;
    logic        load_err, alarm, pm, sec_tick, min_tick, hour_tick, day_tick;
    logic [23:0] digit;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state
    int          m_tod = 0;
    int          m_pre = 0;
    logic [15:0] m_alm = 16'h0;
    logic        e_sec = 0, e_min = 0, e_hour = 0, e_day = 0, e_alarm = 0, e_lerr = 0;

    always #5 clk = ~clk;

    bcd_rtc_param #(.TICK_DIV(TDIV), .DIV_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
        .load(load), .load_time(load_time), .load_err(load_err),
        .alarm_set(alarm_set), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .alarm(alarm), .digit(digit), .pm(pm),
        .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Returns {pm, displayed HHMMSS}
    function automatic logic [24:0] disp(input int t, input logic md);
        int h, dh;
        logic p;
        logic [23:0] b;
        b  = to_bcd(t);
        h  = t / 3600;
        dh = h;
        p  = 1'b0;
        if (md) begin
            p  = (h >= 12);
            dh = h % 12;
            if (dh == 0) dh = 12;
        end
        return {p, 4'(dh / 10), 4'(dh % 10), b[15:0]};
    endfunction

    // Reference model: time as seconds of day, prescaler as an integer.
    always @(posedge clk) begin : model
        int t, p, hh, mm, ss;
        bit ok;
        logic [15:0] a;
        logic [23:0] nb;
        logic s_, mi, ho, da, al, le;
        t = m_tod; p = m_pre; a = m_alm;
        s_ = 0; mi = 0; ho = 0; da = 0; al = 0; le = 0;
        if (rst) begin
            t = 0; p = 0; a = 16'h0;
        end else begin
            if (load) begin
                ok = 1;
                for (int i = 0; i < 6; i++) if (load_time[4*i +: 4] > 4'd9) ok = 0;
                hh = load_time[23:20] * 10 + load_time[19:16];
                mm = load_time[15:12] * 10 + load_time[11:8];
                ss = load_time[7:4] * 10 + load_time[3:0];
                if (hh > 23 || mm > 59 || ss > 59) ok = 0;
                if (ok) begin
                    t = hh * 3600 + mm * 60 + ss; p = 0;
                end else begin
                    le = 1;
                end
            end else if (run) begin
                if (p == TDIV - 1) begin
                    p  = 0;
                    t  = (t + 1) % 86400;
                    s_ = 1;
                    mi = (t % 60 == 0);
                    ho = (t % 3600 == 0);
                    da = (t == 0);
                    nb = to_bcd(t);
                    al = alarm_en && (nb[23:8] == m_alm) && (t % 60 == 0);
                end else begin
                    p = p + 1;
                end
            end
            if (alarm_set) a = alarm_time;
        end
        m_tod <= t; m_pre <= p; m_alm <= a;
        e_sec <= s_; e_min <= mi; e_hour <= ho; e_day <= da; e_alarm <= al; e_lerr <= le;
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        logic [24:0] d;
        if (chk_en) begin
            d = disp(m_tod, mode_12h);
            chk("digit", 32'(digit), 32'(d[23:0]));
            chk("pm", 32'(pm), 32'(d[24]));
            chk("sec_tick", 32'(sec_tick), 32'(e_sec));
            chk("min_tick", 32'(min_tick), 32'(e_min));
            chk("hour_tick", 32'(hour_tick), 32'(e_hour));
            chk("day_tick", 32'(day_tick), 32'(e_day));
            chk("alarm", 32'(alarm), 32'(e_alarm));
            chk("load_err", 32'(load_err), 32'(e_lerr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (sec_tick === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL tick_timeout: got no sec_tick expected one within 40 cycles");
    endtask

    task automatic do_load(input logic [23:0] v);
        load = 1'b1; load_time = v;
        cyc();
        load = 1'b0;
    endtask

    logic [23:0] h12_in  [4] = '{24'h001500, 24'h115959, 24'h120000, 24'h130500};
    logic [23:0] h12_out [4] = '{24'h121500, 24'h115959, 24'h120000, 24'h010500};
    logic        h12_pm  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [23:0] b;
        int t, sel;
        rst = 1; run = 0; mode_12h = 0; load = 0; load_time = 0;
        alarm_set = 0; alarm_time = 0; alarm_en = 0;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_digit", 32'(digit), 32'h0);
        rst = 0; run = 1;

        // First advance and prescaler hold
        wait_tick();
        chk("first_tick_digit", 32'(digit), 32'h000001);
        cyc();
        run = 0;
        repeat (5) cyc();
        run = 1;
        cyc(); cyc();
        chk("hold_no_tick", 32'(sec_tick), 32'h0);
        cyc();
        chk("hold_tick", 32'(sec_tick), 32'h1);
        chk("hold_digit", 32'(digit), 32'h000002);

        // Day wrap
        do_load(24'h235958);
        chk("load_no_tick", 32'(sec_tick), 32'h0);
        chk("load_digit", 32'(digit), 32'h235958);
        wait_tick();
        wait_tick();
        chk("daywrap_digit", 32'(digit), 32'h000000);
        chk("daywrap_ticks", 32'({sec_tick, min_tick, hour_tick, day_tick}), 32'hF);

        // Invalid loads
        run = 0;
        do_load(24'h236000);
        chk("lerr_min", 32'(load_err), 32'h1);
        chk("lerr_min_digit", 32'(digit), 32'h000000);
        cyc();
        chk("lerr_clear", 32'(load_err), 32'h0);
        do_load(24'h0A0000);
        chk("lerr_nib", 32'(load_err), 32'h1);
        chk("lerr_nib_digit", 32'(digit), 32'h000000);
        cyc();

        // Load on a terminal-count edge
        run = 1;
        wait_tick();
        cyc(); cyc(); cyc();
        do_load(24'h101010);
        chk("tc_load_digit", 32'(digit), 32'h101010);
        chk("tc_load_no_tick", 32'(sec_tick), 32'h0);

        // 12 h display mapping
        run = 0;
        for (int i = 0; i < 4; i++) begin
            do_load(h12_in[i]);
            mode_12h = 1; #1;
            chk("h12_digit", 32'(digit), 32'(h12_out[i]));
            chk("h12_pm", 32'(pm), 32'(h12_pm[i]));
            mode_12h = 0; #1;
            chk("h24_digit", 32'(digit), 32'(h12_in[i]));
            chk("h24_pm", 32'(pm), 32'h0);
        end

        // Alarm
        alarm_set = 1; alarm_time = 16'h0701; alarm_en = 1;
        cyc();
        alarm_set = 0;
        do_load(24'h070058);
        run = 1;
        wait_tick();
        chk("alarm_early", 32'(alarm), 32'h0);
        wait_tick();
        chk("alarm_digit", 32'(digit), 32'h070100);
        chk("alarm_fire", 32'(alarm), 32'h1);
        wait_tick();
        chk("alarm_once", 32'(alarm), 32'h0);
        run = 0; alarm_en = 0;
        do_load(24'h070058);
        run = 1;
        wait_tick(); wait_tick();
        chk("alarm_dis", 32'(alarm), 32'h0);
        run = 0; alarm_en = 1;
        do_load(24'h070100);
        cyc();
        chk("alarm_on_load", 32'(alarm), 32'h0);

        // Reset mid-run clears time and the stored alarm
        do_load(24'h123456);
        run = 1;
        cyc(); cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_run_digit", 32'(digit), 32'h0);
        chk("rst_run_pulses", 32'({sec_tick, min_tick, hour_tick, day_tick, alarm, load_err}), 32'h0);
        do_load(24'h235958);
        wait_tick(); wait_tick();
        chk("rst_alarm_midnight", 32'(alarm), 32'h1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom % 300) == 0;
            run       = ($urandom % 8) != 0;
            alarm_en  = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) mode_12h = ~mode_12h;
            load      = ($urandom % 40) == 0;
            sel       = $urandom % 4;
            case (sel)
                0: load_time = 24'($urandom);
                1: load_time = to_bcd($urandom % 86400);
                2: load_time = to_bcd(86390 + $urandom % 10);
                default: load_time = to_bcd(((m_tod / 60) * 60 + 55 + $urandom % 5) % 86400);
            endcase
            alarm_set = ($urandom % 50) == 0;
            t = ((m_tod / 60 + 1) % 1440) * 60;
            b = to_bcd(t);
            alarm_time = (($urandom % 8) == 0) ? 16'($urandom) : b[23:8];
            cyc();
        end
        rst = 0; load = 0; alarm_set = 0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
